// File: rtl/viterbi_tb_ctrl_if.sv
// Handshake bundle for viterbi_tb_ctrl.
// Decision vectors come in from the ACS stage, and decoded words go out to the consumer.
// The slave modport is the traceback block. The master modport is its environment.
interface viterbi_tb_ctrl_if #(
   parameter int DEPTH = 11
);
   logic             dec_valid;
   logic             dec_ready;
   logic [3:0]       dec_bits;
   logic [1:0]       best_state;
   logic             out_valid;
   logic             out_ready;
   logic [DEPTH-1:0] out_word;

   modport slave (
      input  dec_valid, dec_bits, best_state, out_ready,
      output dec_ready, out_valid, out_word
   );

   modport master (
      output dec_valid, dec_bits, best_state, out_ready,
      input  dec_ready, out_valid, out_word
   );
endinterface

// File: rtl/viterbi_tb_ctrl.sv
// Survivor-memory write sequencer and block traceback engine for the K=3 (4-state) Viterbi decoder.
// FILL writes DEPTH decision columns through wr_idx, which feeds the one-hot column decoder.
// TRACE walks the columns back from best_state and rebuilds the decoded word.
// HOLD presents that word until the consumer takes it.
// Optional feature: define FRAME_CNT_EN to get a 16-bit count of completed frames.
// When it is undefined, frame_cnt is tied to zero.
module viterbi_tb_ctrl #(
   parameter int DEPTH = 11,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   viterbi_tb_ctrl_if.slave bus,
   output logic             o_wr_en,
   output logic [IDX_W-1:0] o_wr_idx,
   output logic [3:0]       o_wr_bits,
   output logic [IDX_W-1:0] o_rd_idx,
   input  logic [3:0]       i_rd_bits,
   output logic [15:0]      o_frame_cnt
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_TRACE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_wr_idx, w_wr_idx_nxt;
   logic [IDX_W-1:0] r_rd_idx, w_rd_idx_nxt;
   logic [1:0]       r_tb_state, w_tb_state_nxt;
   logic [DEPTH-1:0] r_out_word, w_out_word_nxt;
   logic             w_dec_ready;
   logic             w_out_valid;
   logic             w_wr_en;
   logic             w_trace_bit;

   // Next-state, next-datapath and handshake outputs for the FILL/TRACE/HOLD sequencer.
   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_wr_idx_nxt   = r_wr_idx;
      w_rd_idx_nxt   = r_rd_idx;
      w_tb_state_nxt = r_tb_state;
      w_out_word_nxt = r_out_word;
      w_dec_ready    = 1'b0;
      w_out_valid    = 1'b0;
      w_wr_en        = 1'b0;
      w_trace_bit    = i_rd_bits[r_tb_state];

      case (r_state)
         S_FILL: begin
            w_dec_ready = 1'b1;
            w_wr_en     = bus.dec_valid;
            if (bus.dec_valid) begin
               if (r_wr_idx == LAST_IDX) begin
                  // Column DEPTH-1 is the last one, so wrap wr_idx now.
                  // It is then already 0 when the next frame starts.
                  w_wr_idx_nxt   = '0;
                  w_tb_state_nxt = bus.best_state;
                  w_rd_idx_nxt   = LAST_IDX;
                  w_state_nxt    = S_TRACE;
               end else begin
                  w_wr_idx_nxt = r_wr_idx + 1'b1;
               end
            end
         end

         S_TRACE: begin
            // The MSB of the current state is the input bit that led into it.
            // The survivor bit says which predecessor we came from.
            w_out_word_nxt[r_rd_idx] = r_tb_state[1];
            w_tb_state_nxt           = {r_tb_state[0], w_trace_bit};
            if (r_rd_idx == '0) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_rd_idx_nxt = r_rd_idx - 1'b1;
            end
         end

         S_HOLD: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = S_FILL;
            end
         end

         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end

   // FSM state register.
   // NOTE: sequential state is updated with non-blocking assignments, so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Column indices, traceback state and the decoded word.
   // NOTE: out_word is a handful of flops, not an array, so it is cleared with everything else on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx   <= '0;
         r_rd_idx   <= '0;
         r_tb_state <= '0;
         r_out_word <= '0;
      end else begin
         r_wr_idx   <= w_wr_idx_nxt;
         r_rd_idx   <= w_rd_idx_nxt;
         r_tb_state <= w_tb_state_nxt;
         r_out_word <= w_out_word_nxt;
      end
   end

`ifdef FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Count of completed output handshakes. It wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
      end else if (w_out_valid && bus.out_ready) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
`else
   assign o_frame_cnt = 16'd0;
`endif

   assign bus.dec_ready = w_dec_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_word  = r_out_word;
   assign o_wr_en       = w_wr_en;
   assign o_wr_idx      = r_wr_idx;
   assign o_wr_bits     = bus.dec_bits;
   assign o_rd_idx      = r_rd_idx;

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Directed self-checking bench for viterbi_tb_ctrl (DEPTH=11, IDX_W=4).
// A small survivor-array model stores columns on wr_en and returns them combinationally at rd_idx.
// Expected decoded words are worked out by hand:
//   dec_bits=0, best=0 -> 11'h000
//   dec_bits=F, best=3 -> 11'h7FF (the trace state stays at 3)
//   dec_bits=0, best=1 -> 11'h200 (state 1 -> 2 -> 0)
//   dec_bits=0, best=2 -> 11'h400 (state 2 -> 0)
module tb_viterbi_tb_ctrl;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [3:0]  wr_bits;
   logic [3:0]  rd_idx;
   logic [3:0]  rd_bits;
   logic [15:0] frame_cnt;

   logic [3:0]  mem [0:15];

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_frames = 0;
   bit idx_bad = 1'b0;
   bit rd_idle_bad = 1'b0;

   viterbi_tb_ctrl_if #(.DEPTH(11)) bus ();

   viterbi_tb_ctrl #(.DEPTH(11), .IDX_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_wr_en     (wr_en),
      .o_wr_idx    (wr_idx),
      .o_wr_bits   (wr_bits),
      .o_rd_idx    (rd_idx),
      .i_rd_bits   (rd_bits),
      .o_frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Survivor array model.
   always @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_bits;
   end
   assign rd_bits = mem[rd_idx];

   // Index range and idle rd_idx watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_idx > 4'd10 || rd_idx > 4'd10) idx_bad = 1'b1;
      if ((bus.dec_ready || bus.out_valid) && rd_idx != 4'd0) rd_idle_bad = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame_cnt(input string tag);
`ifdef FRAME_CNT_EN
      check(tag, {16'd0, frame_cnt}, exp_frames);
`else
      check(tag, {16'd0, frame_cnt}, 32'd0);
`endif
   endtask

   // Fill 11 columns, then follow the 11 trace cycles.
   // The word is expected in the 12th cycle counted from the cycle of the last accept.
   task automatic run_frame(input logic [3:0] bits, input logic [1:0] best, input bit gapped,
                            input bit pre_ready, input logic [10:0] exp_word);
      for (int i = 0; i < 11; i++) begin
         bus.dec_valid  = 1'b1;
         bus.dec_bits   = bits;
         bus.best_state = (i == 10) ? best : ~best;
         #1;
         check("fill_wr_idx", wr_idx, i);
         check("fill_wr_en", wr_en, 1);
         check("fill_ready", bus.dec_ready, 1);
         check("fill_wr_bits", wr_bits, bits);
         tick();
         if (gapped && i < 10) begin
            bus.dec_valid = 1'b0;
            bus.dec_bits  = ~bits;
            #1;
            check("gap_wr_idx", wr_idx, i + 1);
            check("gap_wr_en", wr_en, 0);
            check("gap_no_trace", bus.dec_ready, 1);
            tick();
         end
      end
      // Upstream keeps offering junk during TRACE; it must not be accepted.
      bus.dec_valid = 1'b1;
      bus.dec_bits  = ~bits;
      bus.out_ready = pre_ready;
      for (int k = 0; k < 11; k++) begin
         #1;
         check("trace_rd_idx", rd_idx, 10 - k);
         check("trace_ready", bus.dec_ready, 0);
         check("trace_wr_en", wr_en, 0);
         check("trace_wr_idx", wr_idx, 0);
         check("trace_valid", bus.out_valid, 0);
         tick();
      end
      #1;
      check("hold_valid", bus.out_valid, 1);
      check("out_word", bus.out_word, exp_word);
      check("hold_ready", bus.dec_ready, 0);
      check("hold_rd_idx", rd_idx, 0);
   endtask

   // Stall in HOLD for the given number of cycles, then complete the handshake.
   task automatic release_hold(input int stall, input logic [10:0] exp_word);
      for (int s = 0; s < stall; s++) begin
         bus.dec_valid = 1'b1;
         bus.out_ready = 1'b0;
         tick();
         #1;
         check("bp_valid", bus.out_valid, 1);
         check("bp_word", bus.out_word, exp_word);
         check("bp_ready", bus.dec_ready, 0);
         check("bp_wr_en", wr_en, 0);
         check("bp_wr_idx", wr_idx, 0);
      end
      bus.out_ready = 1'b1;
      tick();
      exp_frames++;
      bus.dec_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("rel_valid", bus.out_valid, 0);
      check("rel_ready", bus.dec_ready, 1);
      check("rel_wr_idx", wr_idx, 0);
      check_frame_cnt("frame_cnt");
   endtask

   initial begin
      for (int m = 0; m < 16; m++) mem[m] = 4'h0;
      rst_n          = 1'b0;
      bus.dec_valid  = 1'b0;
      bus.dec_bits   = 4'h0;
      bus.best_state = 2'd0;
      bus.out_ready  = 1'b0;
      #3;
      check("rst_ready", bus.dec_ready, 1);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_idx", wr_idx, 0);
      check("rst_rd_idx", rd_idx, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_word", bus.out_word, 0);
      check_frame_cnt("rst_frame_cnt");
      rst_n = 1'b1;
      tick();

      // Zero frame, with out_ready already high when HOLD is entered.
      run_frame(4'h0, 2'd0, 1'b0, 1'b1, 11'h000);
      release_hold(0, 11'h000);

      // All-ones frame with 5 cycles of backpressure.
      run_frame(4'hF, 2'd3, 1'b0, 1'b0, 11'h7FF);
      release_hold(5, 11'h7FF);

      // Single transition back from state 1.
      run_frame(4'h0, 2'd1, 1'b0, 1'b1, 11'h200);
      release_hold(0, 11'h200);

      // Gapped input.
      run_frame(4'h0, 2'd2, 1'b1, 1'b0, 11'h400);
      release_hold(1, 11'h400);

      // All-ones frame again; reset lands in the middle of HOLD.
      run_frame(4'hF, 2'd3, 1'b0, 1'b0, 11'h7FF);
      bus.dec_valid = 1'b1;
      rst_n = 1'b0;
      exp_frames = 0;
      #1;
      check("mid_rst_ready", bus.dec_ready, 1);
      check("mid_rst_wr_en", wr_en, 1);
      check("mid_rst_wr_idx", wr_idx, 0);
      check("mid_rst_rd_idx", rd_idx, 0);
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_word", bus.out_word, 0);
      check_frame_cnt("mid_rst_frame_cnt");
      tick();
      check("in_rst_wr_idx", wr_idx, 0);
      bus.dec_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();

      // Recovery after reset.
      run_frame(4'h0, 2'd1, 1'b0, 1'b1, 11'h200);
      release_hold(0, 11'h200);

      check("idx_range", idx_bad, 0);
      check("rd_idx_idle", rd_idle_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
